// File: rtl/framebuffer_writer_pkg.sv
//------------------------------------------------------------------------------
// fb_pkg : shared frame-buffer constants, state encoding and pixel address map
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fb_pkg;

  localparam int FB_WIDTH  = 64;
  localparam int FB_HEIGHT = 64;
  localparam int CLEAR_LEN = FB_WIDTH * FB_HEIGHT / 2;

  localparam int COL_W  = $clog2(FB_WIDTH);
  localparam int ROW_W  = $clog2(FB_HEIGHT);
  localparam int ADDR_W = $clog2(CLEAR_LEN);

  // Pixel byte layout {X,X,R,R,G,G,B,B}
  localparam int CHAN_W    = 2;
  localparam int RED_LSB   = 4;
  localparam int GREEN_LSB = 2;
  localparam int BLUE_LSB  = 0;

  localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(CLEAR_LEN - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    WAIT_SWAP = 2'd2
  } fb_state_t;

  // Returns {half, row-within-half, column}; the scanner uses the same map.
  function automatic logic [ADDR_W:0] fb_map(input logic [COL_W-1:0] x,
                                              input logic [ROW_W-1:0] y);
    return {y[ROW_W-1], y[ROW_W-2:0], x};
  endfunction

endpackage

`default_nettype wire

// File: rtl/framebuffer_writer.sv
//------------------------------------------------------------------------------
// framebuffer_writer : CPU pixel writes, back-bank clear/fill, tear-free swap
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module framebuffer_writer
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wrValid,
  output logic              wrReady,
  input  logic [COL_W-1:0]  wrX,
  input  logic [ROW_W-1:0]  wrY,
  input  logic [7:0]        wrColor,
  input  logic              clearReq,
  input  logic [7:0]        fillColor,
  input  logic              swapReq,
  input  logic              displayDone,
  output logic              busy,
  output logic              swapped,
  output logic              frontBank,
  output logic [ADDR_W:0]   ramAddr,
  output logic [7:0]        ramData,
  output logic              ramWe0,
  output logic              ramWe1
);

  fb_state_t          state;
  logic               clear_pend;
  logic               swap_pend;
  logic [ADDR_W-1:0]  clear_cnt;
  logic [7:0]         fill;
  logic [ADDR_W:0]    wr_map;

  assign wr_map  = fb_map(wrX, wrY);
  assign wrReady = (state == IDLE) && !clear_pend && !swap_pend;
  assign busy    = (state != IDLE) || clear_pend || swap_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      frontBank  <= 1'b0;
      clear_pend <= 1'b0;
      swap_pend  <= 1'b0;
      clear_cnt  <= '0;
      fill       <= '0;
      ramAddr    <= '0;
      ramData    <= '0;
      ramWe0     <= 1'b0;
      ramWe1     <= 1'b0;
      swapped    <= 1'b0;
    end else begin
      ramWe0  <= 1'b0;
      ramWe1  <= 1'b0;
      swapped <= 1'b0;

      // Fill colour belongs to the request that set the flag; repeats are absorbed.
      if (clearReq && !clear_pend) begin
        clear_pend <= 1'b1;
        fill       <= fillColor;
      end
      if (swapReq) begin
        swap_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (wrValid && wrReady) begin
            ramAddr <= {~frontBank, wr_map[ADDR_W-1:0]};
            ramData <= wrColor;
            ramWe0  <= ~wr_map[ADDR_W];
            ramWe1  <= wr_map[ADDR_W];
          end
          if (clear_pend) begin
            state     <= CLEAR;
            clear_cnt <= '0;
          end else if (swap_pend) begin
            state <= WAIT_SWAP;
          end
        end

        CLEAR: begin
          ramAddr   <= {~frontBank, clear_cnt};
          ramData   <= fill;
          ramWe0    <= 1'b1;
          ramWe1    <= 1'b1;
          clear_cnt <= clear_cnt + 1'b1;
          if (clear_cnt == CLEAR_LAST) begin
            clear_pend <= 1'b0;
            state      <= IDLE;
          end
        end

        WAIT_SWAP: begin
          if (displayDone) begin
            frontBank <= ~frontBank;
            swapped   <= 1'b1;
            swap_pend <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_framebuffer_writer.sv
//------------------------------------------------------------------------------
// tb_framebuffer_writer : directed self-checking bench for framebuffer_writer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_framebuffer_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrValid;
  logic        wrReady;
  logic [5:0]  wrX;
  logic [5:0]  wrY;
  logic [7:0]  wrColor;
  logic        clearReq;
  logic [7:0]  fillColor;
  logic        swapReq;
  logic        displayDone;
  logic        busy;
  logic        swapped;
  logic        frontBank;
  logic [11:0] ramAddr;
  logic [7:0]  ramData;
  logic        ramWe0;
  logic        ramWe1;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  framebuffer_writer dut (
    .clk        (clk),
    .rst        (rst),
    .wrValid    (wrValid),
    .wrReady    (wrReady),
    .wrX        (wrX),
    .wrY        (wrY),
    .wrColor    (wrColor),
    .clearReq   (clearReq),
    .fillColor  (fillColor),
    .swapReq    (swapReq),
    .displayDone(displayDone),
    .busy       (busy),
    .swapped    (swapped),
    .frontBank  (frontBank),
    .ramAddr    (ramAddr),
    .ramData    (ramData),
    .ramWe0     (ramWe0),
    .ramWe1     (ramWe1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int bad;
    int stray;
    int exp_addr;

    rst = 1'b0; wrValid = 1'b0; wrX = '0; wrY = '0; wrColor = '0;
    clearReq = 1'b0; fillColor = '0; swapReq = 1'b0; displayDone = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_we0", 32'(ramWe0), 0);
    chk("rst_we1", 32'(ramWe1), 0);
    chk("rst_addr", 32'(ramAddr), 0);
    chk("rst_data", 32'(ramData), 0);
    chk("rst_front", 32'(frontBank), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_swapped", 32'(swapped), 0);
    rst = 1'b1;

    // 1: single write to the top half
    @(negedge clk);
    chk("t1_ready", 32'(wrReady), 1);
    wrValid = 1'b1; wrX = 6'd5; wrY = 6'd3; wrColor = 8'h15;
    @(negedge clk);
    wrValid = 1'b0;
    chk("t1_we0", 32'(ramWe0), 1);
    chk("t1_we1", 32'(ramWe1), 0);
    chk("t1_addr", 32'(ramAddr), 32'h8C5);
    chk("t1_data", 32'(ramData), 32'h15);

    // 2: bottom-right corner, then four back-to-back writes
    wrValid = 1'b1; wrX = 6'd63; wrY = 6'd63; wrColor = 8'h3F;
    @(negedge clk);
    wrValid = 1'b0;
    chk("t2_we0", 32'(ramWe0), 0);
    chk("t2_we1", 32'(ramWe1), 1);
    chk("t2_addr", 32'(ramAddr), 32'hFFF);
    chk("t2_data", 32'(ramData), 32'h3F);

    wrValid = 1'b1; wrX = 6'd0; wrY = 6'd0; wrColor = 8'h00;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_b2b_ready", 32'(wrReady), 1);
      @(negedge clk);
      if (ramWe0 || ramWe1) n++;
      exp_addr = 2048 + ((i * 16) % 32) * 64 + i;
      chk("t2_b2b_addr", 32'(ramAddr), 32'(exp_addr));
      chk("t2_b2b_half", 32'(ramWe1), (i >= 2) ? 1 : 0);
      if (i < 3) begin
        wrX = 6'(i + 1); wrY = 6'((i + 1) * 16); wrColor = 8'(i + 1);
      end else begin
        wrValid = 1'b0;
      end
    end
    chk("t2_b2b_strobes", 32'(n), 4);

    // 3: clear back bank 1 with 0x2A
    clearReq = 1'b1; fillColor = 8'h2A;
    @(negedge clk);
    clearReq = 1'b0; fillColor = 8'h00;
    chk("t3_ready_pend", 32'(wrReady), 0);
    chk("t3_busy_pend", 32'(busy), 1);
    n = 0; bad = 0;
    for (int c = 0; c < 2200; c++) begin
      @(negedge clk);
      if (ramWe0 && ramWe1) begin
        if (ramAddr !== 12'(12'h800 + n) || ramData !== 8'h2A) bad++;
        if (n < 2047 && wrReady !== 1'b0) bad++;
        n++;
      end else if (n > 0) begin
        break;
      end
    end
    chk("t3_clear_len", 32'(n), 2048);
    chk("t3_clear_bad", 32'(bad), 0);
    chk("t3_busy_after", 32'(busy), 0);
    chk("t3_ready_after", 32'(wrReady), 1);

    // 4: swap waits for the frame boundary
    swapReq = 1'b1;
    @(negedge clk);
    swapReq = 1'b0;
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (frontBank !== 1'b0 || swapped !== 1'b0 || ramWe0 || ramWe1) bad++;
    end
    chk("t4_wait_bad", 32'(bad), 0);
    chk("t4_front_wait", 32'(frontBank), 0);
    chk("t4_busy_wait", 32'(busy), 1);
    chk("t4_ready_wait", 32'(wrReady), 0);
    displayDone = 1'b1;
    @(negedge clk);
    displayDone = 1'b0;
    chk("t4_front_swap", 32'(frontBank), 1);
    chk("t4_swapped", 32'(swapped), 1);
    chk("t4_busy_done", 32'(busy), 0);
    wrValid = 1'b1; wrX = 6'd1; wrY = 6'd1; wrColor = 8'h07;
    @(negedge clk);
    wrValid = 1'b0;
    chk("t4_swapped_off", 32'(swapped), 0);
    chk("t4_write_addr", 32'(ramAddr), 32'h041);
    chk("t4_write_we0", 32'(ramWe0), 1);

    // 5: write + clearReq + swapReq together; stray done during clear
    wrValid = 1'b1; wrX = 6'd2; wrY = 6'd40; wrColor = 8'h33;
    clearReq = 1'b1; fillColor = 8'h11; swapReq = 1'b1;
    chk("t5_ready", 32'(wrReady), 1);
    @(negedge clk);
    wrValid = 1'b0; clearReq = 1'b0; swapReq = 1'b0; fillColor = 8'h00;
    chk("t5_we1", 32'(ramWe1), 1);
    chk("t5_we0", 32'(ramWe0), 0);
    chk("t5_addr", 32'(ramAddr), 32'h202);
    chk("t5_data", 32'(ramData), 32'h33);
    n = 0; bad = 0; stray = 0;
    for (int c = 0; c < 2200; c++) begin
      displayDone = (n == 100 || n == 1500);
      @(negedge clk);
      if (swapped !== 1'b0 || frontBank !== 1'b1) stray++;
      if (ramWe0 && ramWe1) begin
        if (ramAddr !== 12'(n) || ramData !== 8'h11) bad++;
        n++;
      end else if (n > 0) begin
        break;
      end
    end
    displayDone = 1'b0;
    chk("t5_clear_len", 32'(n), 2048);
    chk("t5_clear_bad", 32'(bad), 0);
    chk("t5_no_stray_swap", 32'(stray), 0);
    chk("t5_busy_swap_pend", 32'(busy), 1);
    chk("t5_ready_swap_pend", 32'(wrReady), 0);
    @(negedge clk);
    displayDone = 1'b1;
    @(negedge clk);
    displayDone = 1'b0;
    chk("t5_front_swap", 32'(frontBank), 0);
    chk("t5_swapped", 32'(swapped), 1);

    // 6: reset in the middle of a clear
    clearReq = 1'b1; fillColor = 8'h55;
    @(negedge clk);
    clearReq = 1'b0;
    n = 0;
    for (int c = 0; c < 1100 && n < 1000; c++) begin
      @(negedge clk);
      if (ramWe0 && ramWe1) n++;
    end
    chk("t6_reached_1000", 32'(n), 1000);
    chk("t6_mid_we", 32'(ramWe0), 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_we0", 32'(ramWe0), 0);
    chk("t6_rst_we1", 32'(ramWe1), 0);
    chk("t6_rst_front", 32'(frontBank), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (ramWe0 || ramWe1) bad++;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ramWe0 || ramWe1) bad++;
    end
    chk("t6_no_writes", 32'(bad), 0);
    chk("t6_ready_idle", 32'(wrReady), 1);
    chk("t6_busy_idle", 32'(busy), 0);
    wrValid = 1'b1; wrX = 6'd0; wrY = 6'd0; wrColor = 8'h01;
    @(negedge clk);
    wrValid = 1'b0;
    chk("t6_write_addr", 32'(ramAddr), 32'h800);
    chk("t6_write_data", 32'(ramData), 32'h01);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

`default_nettype wire
